exe_stage: RTL and testbench



---
 rtl/exe_stage_pkg.sv | 51 +++++
 rtl/exe_stage_alu.sv | 46 ++++
 rtl/exe_stage_div.sv | 91 +++++++++
 rtl/exe_stage.sv | 102 ++++++++++
 tb/tb_exe_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage: bus widths, ALU opcode
// bit positions, the decode bundle layout and the divider state encoding.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 167;
  localparam int ES_TO_MS_BUS_WD = 78;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int DIV_CYCLES      = 32;
  localparam int ALU_OP_WD       = 19;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_DIVU  = 16;
  localparam int OP_MOD   = 17;
  localparam int OP_MODU  = 18;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // First member lands in the MSBs, matching the decode bus layout.
  typedef struct packed {
    logic [31:0]          pc;
    logic                 ld_b, ld_h, ld_w, st_b, st_h, st_w, ld_bu, ld_hu;
    logic [31:0]          imm;
    logic [31:0]          rk_value;
    logic [31:0]          rj_value;
    logic                 src1_is_pc, src2_is_imm, src2_is_4;
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 mem_e, mem_we;
    logic [4:0]           wb_dest;
    logic                 wb_rf_we, wb_src_op;
  } ds_bundle_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with a shared 64-bit multiplier; divide/modulo results
// come from the iterative divider and are only selected here.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          src1,
  input  logic [31:0]          src2,
  input  logic [31:0]          div_quotient,
  input  logic [31:0]          div_remainder,
  output logic [31:0]          result
);

  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  // Sign- or zero-extending to 64 bits lets one unsigned multiply serve both mulh variants.
  assign mul_signed = alu_op[OP_MULH];
  assign mul_a      = {{32{mul_signed & src1[31]}}, src1};
  assign mul_b      = {{32{mul_signed & src2[31]}}, src2};
  assign prod       = mul_a * mul_b;

  // NOTE: result gets a default before the one-hot selects so no latch is inferred.
  always_comb begin
    result = '0;
    if (alu_op[OP_ADD])   result = src1 + src2;
    if (alu_op[OP_SUB])   result = src1 - src2;
    if (alu_op[OP_SLT])   result = {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[OP_SLTU])  result = {31'd0, src1 < src2};
    if (alu_op[OP_AND])   result = src1 & src2;
    if (alu_op[OP_NOR])   result = ~(src1 | src2);
    if (alu_op[OP_OR])    result = src1 | src2;
    if (alu_op[OP_XOR])   result = src1 ^ src2;
    if (alu_op[OP_SLL])   result = src1 << src2[4:0];
    if (alu_op[OP_SRL])   result = src1 >> src2[4:0];
    if (alu_op[OP_SRA])   result = $signed(src1) >>> src2[4:0];
    if (alu_op[OP_LUI])   result = src2 << 12;
    if (alu_op[OP_MUL])   result = prod[31:0];
    if (alu_op[OP_MULH] | alu_op[OP_MULHU]) result = prod[63:32];
    if (alu_op[OP_DIV]  | alu_op[OP_DIVU])  result = div_quotient;
    if (alu_op[OP_MOD]  | alu_op[OP_MODU])  result = div_remainder;
  end

endmodule

// File: rtl/exe_stage_div.sv
// Iterative restoring divider on magnitudes; signs and divide-by-zero are
// patched on the way out. Holds its result in DONE until acknowledged.
module exe_stage_div
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, dvz_q, dvz_d;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dvz_d   = dvz_q;
    trial   = {rem_q, quo_q[31]};
    diff    = trial - {1'b0, dvs_q};
    unique case (state_q)
      DIV_IDLE: if (start) begin
        state_d = DIV_RUN;
        rem_d   = '0;
        quo_d   = (is_signed & x[31]) ? -x : x;
        dvs_d   = (is_signed & y[31]) ? -y : y;
        cnt_d   = '0;
        q_neg_d = is_signed & (x[31] ^ y[31]);
        r_neg_d = is_signed & x[31];
        dvz_d   = (y == '0);
      end
      DIV_RUN: begin
        // The dividend shifts out of quo while quotient bits shift in behind it.
        if (diff[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: if (ack) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dvz_q   <= dvz_d;
    end
  end

  assign done      = (state_q == DIV_DONE);
  assign quotient  = dvz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, computes ALU/mul/div results,
// issues the data-SRAM request and exports bypass info to decode.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus
);

  ds_bundle_t  es_bus_q, es_bus_d;
  logic        es_valid_q, es_valid_d;
  logic        is_div, div_done, es_ready_go;
  logic [31:0] src1, src2, alu_result, div_q, div_r;
  logic [4:0]  fwd_dest;

  assign is_div         = |es_bus_q.alu_op[OP_MODU:OP_DIV];
  assign es_ready_go    = ~is_div | div_done;
  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  always_comb begin
    es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
    es_bus_d   = (ds_to_es_valid & es_allowin) ? ds_bundle_t'(ds_to_es_bus) : es_bus_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) es_valid_q <= 1'b0;
    else         es_valid_q <= es_valid_d;
  end

  // NOTE: the payload is qualified by es_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    es_bus_q <= es_bus_d;
  end

  assign src1 = es_bus_q.src1_is_pc  ? es_bus_q.pc  : es_bus_q.rj_value;
  assign src2 = es_bus_q.src2_is_imm ? es_bus_q.imm :
                es_bus_q.src2_is_4   ? 32'd4        : es_bus_q.rk_value;

  exe_stage_div u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (es_valid_q & is_div),
    .is_signed (es_bus_q.alu_op[OP_DIV] | es_bus_q.alu_op[OP_MOD]),
    .x         (src1),
    .y         (src2),
    .ack       (es_to_ms_valid & ms_allowin),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  exe_stage_alu u_alu (
    .alu_op        (es_bus_q.alu_op),
    .src1          (src1),
    .src2          (src2),
    .div_quotient  (div_q),
    .div_remainder (div_r),
    .result        (alu_result)
  );

  assign data_sram_en   = es_valid_q & es_bus_q.mem_e & ms_allowin;
  assign data_sram_addr = alu_result;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = es_bus_q.rk_value;
    if (es_bus_q.st_b) begin
      data_sram_we    = 4'b0001 << alu_result[1:0];
      data_sram_wdata = {4{es_bus_q.rk_value[7:0]}};
    end else if (es_bus_q.st_h) begin
      data_sram_we    = 4'b0011 << {alu_result[1], 1'b0};
      data_sram_wdata = {2{es_bus_q.rk_value[15:0]}};
    end else if (es_bus_q.st_w) begin
      data_sram_we    = 4'b1111;
    end
    if (!(es_valid_q & es_bus_q.mem_we)) data_sram_we = 4'b0000;
  end

  assign es_to_ms_bus = {es_bus_q.pc, alu_result,
                         es_bus_q.ld_b, es_bus_q.ld_h, es_bus_q.ld_w,
                         es_bus_q.ld_bu, es_bus_q.ld_hu,
                         alu_result[1:0], es_bus_q.wb_dest,
                         es_bus_q.wb_rf_we, es_bus_q.wb_src_op};

  // The write-enable is folded into the destination: a non-writing op reports r0,
  // which decode never treats as a hazard.
  assign fwd_dest   = es_bus_q.wb_rf_we ? es_bus_q.wb_dest : 5'd0;
  assign es_fwd_bus = {es_valid_q, es_bus_q.wb_src_op, fwd_dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of ALU vectors plus hand-written
// sequences for stores/loads, back-pressure, divides and async reset.
module tb_exe_stage;

  logic         clk;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [166:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [77:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [38:0]  es_fwd_bus;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PC = 32'h1c00_0000;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_bus      (es_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [2:0]  sel;
    logic [31:0] rj;
    logic [31:0] rk;
    logic [31:0] imm;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  alu_vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] oh(input int i);
    logic [18:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // {pc, ld_b ld_h ld_w st_b st_h st_w ld_bu ld_hu, imm, rk, rj,
  //  src1_is_pc src2_is_imm src2_is_4, alu_op, mem_e, mem_we, dest, rf_we, src_op}
  function automatic logic [166:0] mk(input logic [31:0] pc, input logic [7:0] mem,
                                      input logic [31:0] imm, input logic [31:0] rk,
                                      input logic [31:0] rj, input logic [2:0] sel,
                                      input logic [18:0] op, input logic mem_e,
                                      input logic mem_we, input logic [4:0] dest,
                                      input logic rf_we, input logic src_op);
    return {pc, mem, imm, rk, rj, sel, op, mem_e, mem_we, dest, rf_we, src_op};
  endfunction

  // Presents one bundle for a single edge; returns 1 time unit after the latching edge.
  task automatic send(input logic [166:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic run_div(input int op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string name);
    int n;
    n = 0;
    send(mk(PC, 8'h00, 32'd0, y, x, 3'b000, oh(op), 1'b0, 1'b0, 5'd7, 1'b1, 1'b0));
    while (!es_allowin && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, " stall cycles"}, 64'(n), 64'd33);
    check({name, " valid"}, {63'd0, es_to_ms_valid}, 64'd1);
    check({name, " result"}, {32'd0, es_to_ms_bus[45:14]}, {32'd0, exp});
    @(posedge clk); #1;
    check({name, " drained"}, {63'd0, es_to_ms_valid}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{0,  3'b000, 32'd5,        32'd7,        32'd0,        32'd12,         "add"};
    vecs[1]  = '{1,  3'b000, 32'd5,        32'd7,        32'd0,        32'hFFFF_FFFE,  "sub"};
    vecs[2]  = '{2,  3'b000, 32'hFFFF_FFFF, 32'd1,       32'd0,        32'd1,          "slt neg"};
    vecs[3]  = '{3,  3'b000, 32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0,          "sltu big"};
    vecs[4]  = '{3,  3'b000, 32'd1,        32'hFFFF_FFFF, 32'd0,       32'd1,          "sltu small"};
    vecs[5]  = '{4,  3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,      32'h00F0_000F,  "and"};
    vecs[6]  = '{5,  3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,      32'h000F_F000,  "nor"};
    vecs[7]  = '{6,  3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,      32'hFFF0_0FFF,  "or"};
    vecs[8]  = '{7,  3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,      32'hFF00_0FF0,  "xor"};
    vecs[9]  = '{8,  3'b000, 32'd1,        32'h0000_003F, 32'd0,       32'h8000_0000,  "sll"};
    vecs[10] = '{9,  3'b000, 32'h8000_0000, 32'd4,        32'd0,       32'h0800_0000,  "srl"};
    vecs[11] = '{10, 3'b000, 32'h8000_0000, 32'd4,        32'd0,       32'hF800_0000,  "sra"};
    vecs[12] = '{11, 3'b010, 32'd0,        32'd0,        32'h0001_2345, 32'h1234_5000, "lui"};
    vecs[13] = '{12, 3'b000, 32'h0001_0001, 32'h0001_0001, 32'd0,      32'h0002_0001,  "mul"};
    vecs[14] = '{13, 3'b000, 32'h8000_0000, 32'd2,        32'd0,       32'hFFFF_FFFF,  "mulh"};
    vecs[15] = '{14, 3'b000, 32'h8000_0000, 32'd2,        32'd0,       32'h0000_0001,  "mulhu"};
    vecs[16] = '{0,  3'b101, 32'd0,        32'd0,        32'd0,        32'h1c00_0004,  "pc+4"};
    vecs[17] = '{0,  3'b010, 32'h100,      32'd0,        32'hFFFF_FFFC, 32'h0000_00FC, "addi neg"};
    vecs[18] = '{-1, 3'b000, 32'd5,        32'd7,        32'd0,        32'd0,          "no op"};

    resetn         = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    #12;
    check("reset es_to_ms_valid", {63'd0, es_to_ms_valid}, 64'd0);
    check("reset sram_en", {63'd0, data_sram_en}, 64'd0);
    check("reset sram_we", {60'd0, data_sram_we}, 64'd0);
    check("reset fwd valid", {63'd0, es_fwd_bus[38]}, 64'd0);
    check("reset allowin", {63'd0, es_allowin}, 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic add with pass-through fields and forward bus.
    send(mk(PC, 8'h00, 32'd0, 32'd7, 32'd5, 3'b000, oh(0), 1'b0, 1'b0, 5'd3, 1'b1, 1'b0));
    check("add valid", {63'd0, es_to_ms_valid}, 64'd1);
    check("add pc", {32'd0, es_to_ms_bus[77:46]}, {32'd0, PC});
    check("add dest", {59'd0, es_to_ms_bus[6:2]}, 64'd3);
    check("add fwd", {25'd0, es_fwd_bus}, {25'd0, 1'b1, 1'b0, 5'd3, 32'd12});
    @(posedge clk); #1;
    check("add drained", {63'd0, es_to_ms_valid}, 64'd0);

    for (int i = 0; i < 19; i++) begin
      send(mk(PC, 8'h00, vecs[i].imm, vecs[i].rk, vecs[i].rj, vecs[i].sel, oh(vecs[i].op),
              1'b0, 1'b0, 5'd3, 1'b1, 1'b0));
      check({vecs[i].name, " result"}, {32'd0, es_to_ms_bus[45:14]}, {32'd0, vecs[i].exp});
      @(posedge clk); #1;
    end

    // st.b at 0x1003.
    send(mk(PC, 8'b0001_0000, 32'd3, 32'h1234_56A5, 32'h1000, 3'b010, oh(0), 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    check("st.b en", {63'd0, data_sram_en}, 64'd1);
    check("st.b we", {60'd0, data_sram_we}, 64'b1000);
    check("st.b addr", {32'd0, data_sram_addr}, 64'h1003);
    check("st.b wdata", {32'd0, data_sram_wdata}, 64'hA5A5_A5A5);
    @(posedge clk); #1;
    check("st.b en one cycle", {63'd0, data_sram_en}, 64'd0);

    // st.h at 0x1002.
    send(mk(PC, 8'b0000_1000, 32'd2, 32'h0000_BEEF, 32'h1000, 3'b010, oh(0), 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    check("st.h we", {60'd0, data_sram_we}, 64'b1100);
    check("st.h wdata", {32'd0, data_sram_wdata}, 64'hBEEF_BEEF);
    @(posedge clk); #1;

    // ld.w at 0x2006 into r9.
    send(mk(PC, 8'b0010_0000, 32'd6, 32'd0, 32'h2000, 3'b010, oh(0), 1'b1, 1'b0, 5'd9, 1'b1, 1'b1));
    check("ld.w en", {63'd0, data_sram_en}, 64'd1);
    check("ld.w we", {60'd0, data_sram_we}, 64'd0);
    check("ld.w addr", {32'd0, data_sram_addr}, 64'h2006);
    check("ld.w ld_type", {59'd0, es_to_ms_bus[13:9]}, 64'b00100);
    check("ld.w addr_lo", {62'd0, es_to_ms_bus[8:7]}, 64'd2);
    check("ld.w fwd hdr", {57'd0, es_fwd_bus[38:32]}, {57'd0, 1'b1, 1'b1, 5'd9});
    @(posedge clk); #1;

    // Back-pressure: st.w held for three cycles, then one transfer.
    ms_allowin = 1'b0;
    send(mk(PC, 8'b0000_0100, 32'd8, 32'hCAFE_F00D, 32'h100, 3'b010, oh(0), 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      check("hold allowin", {63'd0, es_allowin}, 64'd0);
      check("hold sram_en", {63'd0, data_sram_en}, 64'd0);
      check("hold valid", {63'd0, es_to_ms_valid}, 64'd1);
      check("hold addr", {32'd0, es_to_ms_bus[45:14]}, 64'h108);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    #1;
    check("release sram_en", {63'd0, data_sram_en}, 64'd1);
    check("release we", {60'd0, data_sram_we}, 64'b1111);
    check("release wdata", {32'd0, data_sram_wdata}, 64'hCAFE_F00D);
    @(posedge clk); #1;
    check("release single", {63'd0, es_to_ms_valid}, 64'd0);
    check("release en off", {63'd0, data_sram_en}, 64'd0);

    // Divides.
    run_div(15, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div -7/2");
    run_div(17, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "mod -7%2");
    run_div(15, 32'd5,         32'd0,        32'hFFFF_FFFF, "div by 0");
    run_div(17, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, "mod by 0");
    run_div(16, 32'd100,       32'd7,        32'd14,        "divu");
    run_div(18, 32'd100,       32'd7,        32'd2,         "modu");
    run_div(15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
    run_div(17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "mod ovf");

    // Async reset in the middle of a divide, then a fresh divide.
    send(mk(PC, 8'h00, 32'd0, 32'd3, 32'd50, 3'b000, oh(15), 1'b0, 1'b0, 5'd7, 1'b1, 1'b0));
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid-div stalled", {63'd0, es_allowin}, 64'd0);
    resetn = 1'b0;
    #1;
    check("abort valid", {63'd0, es_to_ms_valid}, 64'd0);
    check("abort fwd valid", {63'd0, es_fwd_bus[38]}, 64'd0);
    check("abort allowin", {63'd0, es_allowin}, 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("after reset idle", {63'd0, es_to_ms_valid}, 64'd0);
    run_div(15, 32'd50, 32'd3, 32'd16, "div after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
